// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared Hack ALU word width, ctrl bit positions and named encodings
package hack_pkg;

    localparam int WORD_W = 16;

    // Bit positions inside ctrl = {zx,nx,zy,ny,f,no}
    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] ALU_ZERO    = 6'b101010;
    localparam logic [5:0] ALU_ONE     = 6'b111111;
    localparam logic [5:0] ALU_NEG1    = 6'b111010;
    localparam logic [5:0] ALU_X       = 6'b001100;
    localparam logic [5:0] ALU_NOTX    = 6'b001101;
    localparam logic [5:0] ALU_XPLUSY  = 6'b000010;
    localparam logic [5:0] ALU_XMINUSY = 6'b010011;
    localparam logic [5:0] ALU_XANDY   = 6'b000000;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operation/result handshake bundle for alu_pipe
// slave : DUT view (takes in_valid/x/y/ctrl/out_ready, drives in_ready/out_valid/out/zr/ng)
// master: producer/consumer view, directions mirrored
interface alu_pipe_if
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;

    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng
    );

    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );
endinterface

// File: rtl/alu_pre.sv
// rtl/alu_pre.sv - combinational zero/negate for one ALU operand
// d_i : operand, z_i : force to zero, n_i : invert after zeroing, d_o : result
module alu_pre
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic             z_i,
    input  logic             n_i,
    output logic [WIDTH-1:0] d_o
);
    // The inverter block is fixed at 16 bits, so the operand is tiled over
    // as many copies as needed; padding bits are never used.
    localparam int CHUNKS = (WIDTH + 15) / 16;
    localparam int PW     = CHUNKS * 16;

    logic [WIDTH-1:0] zeroed;
    logic [PW-1:0]    pad;
    logic [PW-1:0]    inv;

    assign zeroed = z_i ? '0 : d_i;
    assign pad    = PW'(zeroed);

    for (genvar i = 0; i < CHUNKS; i++) begin : g_not
        not16 u_not (
            .in_i  (pad[i*16 +: 16]),
            .out_o (inv[i*16 +: 16])
        );
    end

    assign d_o = n_i ? inv[WIDTH-1:0] : zeroed;
endmodule

// File: rtl/not16.sv
// rtl/not16.sv - existing 16-bit bitwise inversion stage
// in_i : 16-bit word, out_o : ~in_i
module not16 (
    input  logic [15:0] in_i,
    output logic [15:0] out_o
);
    assign out_o = ~in_i;
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined Hack ALU with valid/ready on both sides
// clk   : system clock, rising edge
// rst_n : synchronous active-low reset
// bus   : alu_pipe_if.slave (operation in, result + zr/ng out)
// busy  : either stage holds an operation
module alu_pipe
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus,
    output logic        busy
);
    logic [WIDTH-1:0] xa_c, ya_c, r_c;
    logic             s1_load, s2_load;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] xa_q, xa_d, ya_q, ya_d;
    logic             f_q, f_d, no_q, no_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d, ng_q, ng_d;

    alu_pre #(.WIDTH(WIDTH)) u_pre_x (
        .d_i (bus.x),
        .z_i (bus.ctrl[CTRL_ZX]),
        .n_i (bus.ctrl[CTRL_NX]),
        .d_o (xa_c)
    );

    alu_pre #(.WIDTH(WIDTH)) u_pre_y (
        .d_i (bus.y),
        .z_i (bus.ctrl[CTRL_ZY]),
        .n_i (bus.ctrl[CTRL_NY]),
        .d_o (ya_c)
    );

    always_comb begin
        // s2 can take s1's entry whenever its own slot frees this edge,
        // and s1 likewise when its entry moves on, so a full pipe streams.
        s2_load = s1_valid_q && (!s2_valid_q || bus.out_ready);
        s1_load = bus.in_valid && (!s1_valid_q || s2_load);

        r_c = f_q ? (xa_q + ya_q) : (xa_q & ya_q);
        if (no_q) begin
            r_c = ~r_c;
        end

        s1_valid_d = s1_valid_q;
        xa_d       = xa_q;
        ya_d       = ya_q;
        f_d        = f_q;
        no_d       = no_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        zr_d       = zr_q;
        ng_d       = ng_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            xa_d       = xa_c;
            ya_d       = ya_c;
            f_d        = bus.ctrl[CTRL_F];
            no_d       = bus.ctrl[CTRL_NO];
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        // Result registers only change on a load, so they hold while stalled
        // and keep the last value once the stage drains.
        if (s2_load) begin
            s2_valid_d = 1'b1;
            out_d      = r_c;
            zr_d       = (r_c == '0);
            ng_d       = r_c[WIDTH-1];
        end else if (s2_valid_q && bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            xa_q       <= '0;
            ya_q       <= '0;
            f_q        <= 1'b0;
            no_q       <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            xa_q       <= xa_d;
            ya_q       <= ya_d;
            f_q        <= f_d;
            no_q       <= no_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
        end
    end

    assign bus.in_ready  = rst_n && (!s1_valid_q || !s2_valid_q || bus.out_ready);
    assign bus.out_valid = s2_valid_q;
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign busy          = s1_valid_q || s2_valid_q;
endmodule
